// File: rtl/core_mac_acc_if.sv
// Operand stream in, accumulated dot-product result out, for core_mac_acc.
// master drives operands and accepts results; slave is the MAC block.
interface core_mac_acc_if #(
  parameter int MAC_NUM   = 8,
  parameter int IDATA_BIT = 8,
  parameter int ACC_BIT   = 32,
  parameter int CNT_BIT   = 16
);
  logic [IDATA_BIT*MAC_NUM-1:0] idataA;
  logic [IDATA_BIT*MAC_NUM-1:0] idataB;
  logic                         idata_valid;
  logic                         idata_last;
  logic                         idata_ready;
  logic [ACC_BIT-1:0]           odata;
  logic [CNT_BIT-1:0]           odata_cnt;
  logic                         odata_ovf;
  logic                         odata_valid;
  logic                         odata_ready;

  modport master (
    output idataA, idataB, idata_valid, idata_last, odata_ready,
    input  idata_ready, odata, odata_cnt, odata_ovf, odata_valid
  );

  modport slave (
    input  idataA, idataB, idata_valid, idata_last, odata_ready,
    output idata_ready, odata, odata_cnt, odata_ovf, odata_valid
  );
endinterface

// File: rtl/core_mac_acc.sv
// Lane-parallel multiply, adder tree and saturating accumulator; last beat to result in 3 edges.
// A held, unaccepted result freezes the whole pipeline and drops idata_ready.
module core_mac_acc #(
  parameter int MAC_NUM   = 8,
  parameter int IDATA_BIT = 8,
  parameter int ACC_BIT   = 32,
  parameter int SIGNED    = 1,
  parameter int CNT_BIT   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  core_mac_acc_if.slave    bus
);
  localparam int   PROD_W = 2 * IDATA_BIT;
  localparam int   LVL    = $clog2(MAC_NUM);
  localparam int   SUM_W  = PROD_W + LVL;
  localparam logic SGN    = (SIGNED != 0);
  localparam logic [ACC_BIT-1:0] SMAX = {1'b0, {(ACC_BIT-1){1'b1}}};
  localparam logic [ACC_BIT-1:0] SMIN = {1'b1, {(ACC_BIT-1){1'b0}}};

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;

  function automatic logic [PROD_W-1:0] ext_op(input logic [IDATA_BIT-1:0] v);
    return {{IDATA_BIT{v[IDATA_BIT-1] & SGN}}, v};
  endfunction

  logic              stall;
  logic [PROD_W-1:0] prod_nxt [MAC_NUM];
  logic [PROD_W-1:0] s1_prod  [MAC_NUM];
  logic              s1_vld, s1_last;
  logic [SUM_W-1:0]  node [1:2*MAC_NUM-1];
  logic [ACC_BIT-1:0] sum_ext;
  logic [ACC_BIT-1:0] s2_sum;
  logic              s2_vld, s2_last;
  acc_state_t        state, state_nxt;
  logic [ACC_BIT-1:0] acc, acc_nxt, base;
  logic [CNT_BIT-1:0] cnt, cnt_nxt;
  logic              ovf, ovf_nxt, ovf_hit;
  logic [ACC_BIT:0]  wide;
  logic              advance, load;

  assign stall           = bus.odata_valid && !bus.odata_ready;
  assign bus.idata_ready = !stall;
  assign advance         = !stall && s2_vld;
  assign load            = advance && s2_last;

  // Operands are widened to the product width first, so the low PROD_W bits
  // of an unsigned multiply give the correct signed product as well.
  always_comb begin
    for (int i = 0; i < MAC_NUM; i++) begin
      prod_nxt[i] = ext_op(bus.idataA[i*IDATA_BIT +: IDATA_BIT]) *
                    ext_op(bus.idataB[i*IDATA_BIT +: IDATA_BIT]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else if (!stall) begin
      s1_vld  <= bus.idata_valid;
      s1_last <= bus.idata_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) s1_prod <= prod_nxt;
  end

  // Heap-ordered tree: leaves at MAC_NUM..2*MAC_NUM-1, root at node[1].
  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < MAC_NUM; i++) begin
      node[MAC_NUM+i] = {{LVL{s1_prod[i][PROD_W-1] & SGN}}, s1_prod[i]};
    end
    for (int i = MAC_NUM - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i+1];
    end
    if (SGN) sum_ext = ACC_BIT'($signed(node[1]));
    else     sum_ext = ACC_BIT'(node[1]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else if (!stall) begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) s2_sum <= sum_ext;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= ACC_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (advance) state_nxt = s2_last ? ACC_IDLE : ACC_RUN;
  end

  // Starting a result accumulates onto zero, which can never saturate.
  always_comb begin
    base    = (state == ACC_RUN) ? acc : '0;
    wide    = '0;
    ovf_hit = 1'b0;
    acc_nxt = '0;
    if (SGN) begin
      wide    = {base[ACC_BIT-1], base} + {s2_sum[ACC_BIT-1], s2_sum};
      ovf_hit = wide[ACC_BIT] ^ wide[ACC_BIT-1];
      acc_nxt = ovf_hit ? (wide[ACC_BIT] ? SMIN : SMAX) : wide[ACC_BIT-1:0];
    end else begin
      wide    = {1'b0, base} + {1'b0, s2_sum};
      ovf_hit = wide[ACC_BIT];
      acc_nxt = ovf_hit ? {ACC_BIT{1'b1}} : wide[ACC_BIT-1:0];
    end
    cnt_nxt = (state == ACC_RUN) ? ((&cnt) ? cnt : cnt + CNT_BIT'(1)) : CNT_BIT'(1);
    ovf_nxt = ((state == ACC_RUN) && ovf) || ovf_hit;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (advance) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.odata       <= '0;
      bus.odata_cnt   <= '0;
      bus.odata_ovf   <= 1'b0;
      bus.odata_valid <= 1'b0;
    end else if (!stall) begin
      bus.odata_valid <= load;
      if (load) begin
        bus.odata     <= acc_nxt;
        bus.odata_cnt <= cnt_nxt;
        bus.odata_ovf <= ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_core_mac_acc.sv
// Three MAC configurations share one operand stream; each result is checked against a reference model.
module tb_core_mac_acc;
  typedef struct packed {
    logic [63:0] dat;
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  core_mac_acc_if #(.MAC_NUM(8), .IDATA_BIT(8), .ACC_BIT(32), .CNT_BIT(16)) if0 ();
  core_mac_acc_if #(.MAC_NUM(8), .IDATA_BIT(8), .ACC_BIT(32), .CNT_BIT(16)) if1 ();
  core_mac_acc_if #(.MAC_NUM(8), .IDATA_BIT(8), .ACC_BIT(20), .CNT_BIT(16)) if2 ();

  core_mac_acc #(.MAC_NUM(8), .IDATA_BIT(8), .ACC_BIT(32), .SIGNED(1), .CNT_BIT(16))
    dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  core_mac_acc #(.MAC_NUM(8), .IDATA_BIT(8), .ACC_BIT(32), .SIGNED(0), .CNT_BIT(16))
    dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  core_mac_acc #(.MAC_NUM(8), .IDATA_BIT(8), .ACC_BIT(20), .SIGNED(1), .CNT_BIT(16))
    dut2 (.clk(clk), .rstn(rstn), .bus(if2));

  assign if1.idataA = if0.idataA;      assign if2.idataA = if0.idataA;
  assign if1.idataB = if0.idataB;      assign if2.idataB = if0.idataB;
  assign if1.idata_valid = if0.idata_valid;  assign if2.idata_valid = if0.idata_valid;
  assign if1.idata_last  = if0.idata_last;   assign if2.idata_last  = if0.idata_last;
  assign if1.odata_ready = if0.odata_ready;  assign if2.odata_ready = if0.odata_ready;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  res_t q0[$], q1[$], q2[$];
  longint m_acc[3];
  int     m_cnt[3];
  bit     m_ovf[3];
  bit     m_run[3];

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int acc_w(input int d);
    return (d == 2) ? 20 : 32;
  endfunction

  function automatic bit sgn(input int d);
    return d != 1;
  endfunction

  function automatic longint beat_sum(input logic [63:0] a, input logic [63:0] b, input bit s);
    longint t, xv, yv;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      if (s) begin
        xv = $signed(a[i*8 +: 8]);
        yv = $signed(b[i*8 +: 8]);
      end else begin
        xv = a[i*8 +: 8];
        yv = b[i*8 +: 8];
      end
      t += xv * yv;
    end
    return t;
  endfunction

  task automatic model_beat(input logic [63:0] a, input logic [63:0] b, input bit last);
    longint s, mx, mn;
    logic [63:0] mask;
    res_t r;
    for (int d = 0; d < 3; d++) begin
      s    = beat_sum(a, b, sgn(d));
      mask = (64'd1 << acc_w(d)) - 64'd1;
      if (sgn(d)) begin
        mx = (longint'(1) <<< (acc_w(d) - 1)) - 1;
        mn = -mx - 1;
      end else begin
        mx = longint'(mask);
        mn = 0;
      end
      if (!m_run[d]) begin
        m_acc[d] = s; m_cnt[d] = 1; m_ovf[d] = 1'b0;
      end else begin
        m_acc[d] += s;
        if (m_acc[d] > mx) begin m_acc[d] = mx; m_ovf[d] = 1'b1; end
        else if (m_acc[d] < mn) begin m_acc[d] = mn; m_ovf[d] = 1'b1; end
        if (m_cnt[d] < 65535) m_cnt[d]++;
      end
      if (last) begin
        r.dat = 64'(m_acc[d]) & mask;
        r.cnt = 16'(m_cnt[d]);
        r.ovf = m_ovf[d];
        case (d)
          0:       q0.push_back(r);
          1:       q1.push_back(r);
          default: q2.push_back(r);
        endcase
      end
      m_run[d] = !last;
    end
  endtask

  task automatic pop_check(input int d, input logic vld, input logic [63:0] dat,
                           input logic [15:0] cnt, input logic ovf);
    res_t r;
    int   sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    check_val($sformatf("vld%0d", d), 64'(vld), 64'd1);
    if (sz == 0) begin
      check_val($sformatf("sb_empty%0d", d), 64'(sz), 64'd1);
    end else begin
      case (d)
        0:       r = q0.pop_front();
        1:       r = q1.pop_front();
        default: r = q2.pop_front();
      endcase
      check_val($sformatf("odata%0d", d), dat, r.dat);
      check_val($sformatf("odata_cnt%0d", d), 64'(cnt), 64'(r.cnt));
      check_val($sformatf("odata_ovf%0d", d), 64'(ovf), 64'(r.ovf));
    end
  endtask

  logic [31:0] hold_dat;
  logic [15:0] hold_cnt;
  logic        hold_ovf;
  bit          was_stall = 1'b0;

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (if0.odata_valid && if0.odata_ready) begin
        pop_check(0, if0.odata_valid, 64'(if0.odata), if0.odata_cnt, if0.odata_ovf);
        pop_check(1, if1.odata_valid, 64'(if1.odata), if1.odata_cnt, if1.odata_ovf);
        pop_check(2, if2.odata_valid, 64'(if2.odata), if2.odata_cnt, if2.odata_ovf);
      end
      if (if0.odata_valid && !if0.odata_ready) begin
        check_val("stall_idata_ready", 64'(if0.idata_ready), 64'd0);
        if (was_stall) begin
          check_val("hold_odata", 64'(if0.odata), 64'(hold_dat));
          check_val("hold_cnt", 64'(if0.odata_cnt), 64'(hold_cnt));
          check_val("hold_ovf", 64'(if0.odata_ovf), 64'(hold_ovf));
        end
        hold_dat  = if0.odata;
        hold_cnt  = if0.odata_cnt;
        hold_ovf  = if0.odata_ovf;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
    end else begin
      was_stall = 1'b0;
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input bit last);
    int  guard;
    bit  ok;
    guard = 0;
    ok    = 1'b0;
    if0.idataA = a;  if0.idataB = b;
    if0.idata_last = last;  if0.idata_valid = 1'b1;
    while (!ok && guard < 200) begin
      @(negedge clk);
      if (if0.idata_ready) ok = 1'b1;
      else guard++;
    end
    if (ok) begin
      @(posedge clk);
      model_beat(a, b, last);
    end else begin
      check_val("send_timeout", 64'(guard), 64'd0);
    end
    #1;
    if0.idata_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    check_val("drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int lat;
    int t0;
    for (int d = 0; d < 3; d++) m_run[d] = 1'b0;
    rstn = 1'b0;
    if0.idataA = '0;  if0.idataB = '0;
    if0.idata_valid = 1'b0;  if0.idata_last = 1'b0;
    if0.odata_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_odata_valid", 64'(if0.odata_valid), 64'd0);
    check_val("rst_odata", 64'(if0.odata), 64'd0);
    check_val("rst_odata_cnt", 64'(if0.odata_cnt), 64'd0);
    check_val("rst_odata_ovf", 64'(if0.odata_ovf), 64'd0);
    rstn = 1'b1;
    check_val("rst_idata_ready", 64'(if0.idata_ready), 64'd1);

    // Single beat: latency and a hand-computed value.
    if0.idataA = {8{8'd2}};  if0.idataB = {8{8'd3}};
    if0.idata_last = 1'b1;   if0.idata_valid = 1'b1;
    @(posedge clk);
    model_beat({8{8'd2}}, {8{8'd3}}, 1'b1);
    #1;
    if0.idata_valid = 1'b0;
    lat = 1;
    while (!if0.odata_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", 64'(lat), 64'd3);
    check_val("one_beat_odata", 64'(if0.odata), 64'd48);
    drain();

    // Large negative operands, then a fresh single-beat result.
    for (int i = 0; i < 3; i++) send({8{8'h80}}, {8{8'h80}}, i == 2);
    send({8{8'hff}}, {8{8'h01}}, 1'b1);
    send({8{8'hff}}, {8{8'hff}}, 1'b1);
    // Four beats saturate the 20-bit accumulator; the next result starts clean.
    for (int i = 0; i < 4; i++) send({8{8'h80}}, {8{8'h80}}, i == 3);
    send({8{8'h01}}, {8{8'h01}}, 1'b1);
    drain();

    // Reset in the middle of a result discards the partial sum.
    send(rnd64(), rnd64(), 1'b0);
    send(rnd64(), rnd64(), 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int d = 0; d < 3; d++) m_run[d] = 1'b0;
    send({8{8'h01}}, {8{8'h01}}, 1'b1);
    drain();

    // Back-to-back streaming with the result side always ready.
    t0 = cyc;
    for (int i = 0; i < 24; i++) send(rnd64(), rnd64(), (i % 4) == 3);
    check_val("throughput", 64'(cyc - t0), 64'd24);
    drain();

    // Streaming while the result side stalls.
    fork
      begin
        for (int i = 0; i < 40; i++) send(rnd64(), rnd64(), $urandom_range(0, 2) == 0);
        send(rnd64(), rnd64(), 1'b1);
      end
      begin
        int g;
        repeat (6) @(posedge clk);
        #1;
        if0.odata_ready = 1'b0;
        g = 0;
        while (!if0.odata_valid && g < 50) begin
          @(posedge clk);
          #1;
          g++;
        end
        repeat (5) @(posedge clk);
        #1;
        if0.odata_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          if0.odata_ready = ($urandom_range(0, 1) == 1);
        end
        if0.odata_ready = 1'b1;
      end
    join
    drain();

    check_val("q0_left", 64'(q0.size()), 64'd0);
    check_val("q2_left", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
